// File: rtl/comm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : comm_pkg                                                          |
// | Purpose : Shared constants and types for the OFDM receive chain.            |
// |           State encodings of the symbol scheduler, default datapath sizes   |
// |           (also used by the rescale and fft64 instantiations) and a         |
// |           saturating 8-bit increment helper.                                |
// | Ports   : none (package)                                                    |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package comm_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_SKIP  = 2'd3;

  localparam int NFFT_DEF   = 64;
  localparam int CP_LEN_DEF = 16;
  localparam int WIDTH_DEF  = 11;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_GUARD = ST_GUARD,
    S_DATA  = ST_DATA,
    S_SKIP  = ST_SKIP
  } sym_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comm_sym_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : comm_sym_ctrl                                                     |
// | Purpose : Symbol scheduler between rescale and fftfifo. Aligns to frame     |
// |           sync, strips the cyclic prefix and forwards NFFT samples per      |
// |           symbol, dropping whole symbols when the FIFO lacks room.          |
// | Ports   : CLK, RST (async, active-low)                                      |
// |           sync_i, valid_i, ar_i, ai_i, fifo_level_i   - inputs              |
// |           wr_en_o, ar_o, ai_o                          - FIFO write side    |
// |           sym_start_o, frame_done_o, sym_idx_o,                             |
// |           drop_cnt_o, busy_o                           - status             |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module comm_sym_ctrl
  import comm_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int NFFT       = NFFT_DEF,
  parameter int CP_LEN     = CP_LEN_DEF,
  parameter int SYMS       = 8,
  parameter int FIFO_DEPTH = 128
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    sync_i,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] ar_i,
  input  logic signed [WIDTH-1:0] ai_i,
  input  logic [7:0]              fifo_level_i,
  output logic                    wr_en_o,
  output logic signed [WIDTH-1:0] ar_o,
  output logic signed [WIDTH-1:0] ai_o,
  output logic                    sym_start_o,
  output logic                    frame_done_o,
  output logic [7:0]              sym_idx_o,
  output logic [7:0]              drop_cnt_o,
  output logic                    busy_o
);

  localparam logic [7:0] C_CP_LAST   = 8'(CP_LEN - 1);
  localparam logic [7:0] C_NFFT_LAST = 8'(NFFT - 1);
  localparam logic [7:0] C_SYM_LAST  = 8'(SYMS - 1);

  sym_state_t              r_state, w_state_nx;
  logic [7:0]              r_cnt, w_cnt_nx;
  logic [7:0]              r_idx, w_idx_nx;
  logic [7:0]              r_drop, w_drop_nx;
  logic                    r_wr, w_wr_nx;
  logic                    r_start, w_start_nx;
  logic                    r_done, w_done_nx;
  logic signed [WIDTH-1:0] r_ar, w_ar_nx;
  logic signed [WIDTH-1:0] r_ai, w_ai_nx;

  // State/count as seen by the current sample: a sync in this cycle puts the
  // coincident sample at CP position 0 regardless of where we were.
  sym_state_t              w_st;
  logic [7:0]              w_cnt;
  logic                    w_free_ok;

  // Room for a full symbol: FIFO_DEPTH - level >= NFFT.
  assign w_free_ok = ({24'd0, fifo_level_i} + 32'(NFFT)) <= 32'(FIFO_DEPTH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_idx   <= 8'd0;
      r_drop  <= 8'd0;
      r_wr    <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_ar    <= '0;
      r_ai    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_drop  <= w_drop_nx;
      r_wr    <= w_wr_nx;
      r_start <= w_start_nx;
      r_done  <= w_done_nx;
      r_ar    <= w_ar_nx;
      r_ai    <= w_ai_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_drop_nx  = r_drop;
    w_wr_nx    = 1'b0;
    w_start_nx = 1'b0;
    w_done_nx  = 1'b0;
    w_ar_nx    = r_ar;
    w_ai_nx    = r_ai;
    w_st       = r_state;
    w_cnt      = r_cnt;

    if (sync_i) begin
      // Abandoning a symbol that was being written or skipped counts as a drop.
      if (r_state == S_DATA || r_state == S_SKIP) begin
        w_drop_nx = sat_inc8(r_drop);
      end
      w_st       = S_GUARD;
      w_cnt      = 8'd0;
      w_state_nx = S_GUARD;
      w_cnt_nx   = 8'd0;
      w_idx_nx   = 8'd0;
    end

    if (valid_i) begin
      case (w_st)
        S_GUARD: begin
          if (w_cnt == C_CP_LAST) begin
            w_cnt_nx = 8'd0;
            if (w_free_ok) begin
              w_state_nx = S_DATA;
            end else begin
              w_state_nx = S_SKIP;
              w_drop_nx  = sat_inc8(w_drop_nx);
            end
          end else begin
            w_cnt_nx = w_cnt + 8'd1;
          end
        end
        S_DATA, S_SKIP: begin
          if (w_st == S_DATA) begin
            w_wr_nx    = 1'b1;
            w_start_nx = (w_cnt == 8'd0);
            w_ar_nx    = ar_i;
            w_ai_nx    = ai_i;
          end
          if (w_cnt == C_NFFT_LAST) begin
            w_cnt_nx = 8'd0;
            if (r_idx == C_SYM_LAST) begin
              w_state_nx = S_IDLE;
              w_done_nx  = 1'b1;
            end else begin
              w_idx_nx   = r_idx + 8'd1;
              w_state_nx = S_GUARD;
            end
          end else begin
            w_cnt_nx = w_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_en_o      = r_wr;
  assign ar_o         = r_ar;
  assign ai_o         = r_ai;
  assign sym_start_o  = r_start;
  assign frame_done_o = r_done;
  assign sym_idx_o    = r_idx;
  assign drop_cnt_o   = r_drop;
  assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_comm_sym_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_comm_sym_ctrl                                                  |
// | Purpose : Directed self-checking bench for comm_sym_ctrl (SYMS=2).          |
// | Ports   : none                                                              |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_comm_sym_ctrl;

  logic              CLK;
  logic              RST;
  logic              sync_i;
  logic              valid_i;
  logic [10:0]       ar_i;
  logic [10:0]       ai_i;
  logic [7:0]        fifo_level_i;
  logic              wr_en_o;
  logic [10:0]       ar_o;
  logic [10:0]       ai_o;
  logic              sym_start_o;
  logic              frame_done_o;
  logic [7:0]        sym_idx_o;
  logic [7:0]        drop_cnt_o;
  logic              busy_o;

  comm_sym_ctrl #(
    .WIDTH(11), .NFFT(64), .CP_LEN(16), .SYMS(2), .FIFO_DEPTH(128)
  ) u_dut (
    .CLK(CLK), .RST(RST), .sync_i(sync_i), .valid_i(valid_i),
    .ar_i(ar_i), .ai_i(ai_i), .fifo_level_i(fifo_level_i),
    .wr_en_o(wr_en_o), .ar_o(ar_o), .ai_o(ai_o),
    .sym_start_o(sym_start_o), .frame_done_o(frame_done_o),
    .sym_idx_o(sym_idx_o), .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int in_cyc [256];

  typedef struct {
    logic [10:0] ar;
    logic [10:0] ai;
    logic        st;
    logic        dn;
    logic        bz;
    int          c;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    int v;
    bit st;
    bit dn;
  } exp_t;
  exp_t eq[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (wr_en_o) wq.push_back('{ar_o, ai_o, sym_start_o, frame_done_o, busy_o, cyc});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge, then advance to the next one.
  task automatic cycle(input logic sy, input logic vl, input int v, input logic [7:0] lvl);
    sync_i       = sy;
    valid_i      = vl;
    ar_i         = 11'(v);
    ai_i         = 11'(v + 512);
    fifo_level_i = lvl;
    if (vl) in_cyc[v & 255] = cyc;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 8'd0);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    idle(2);
    RST = 1'b1;
    wq.delete();
    eq.delete();
  endtask

  task automatic add_exp(input int lo, input int hi, input bit last);
    for (int v = lo; v <= hi; v++) eq.push_back('{v, v == lo, last && (v == hi)});
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 64'(wq.size()), 64'(eq.size()));
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      chk({tag, "_word"}, {wq[i].ar, wq[i].ai, wq[i].st, wq[i].dn, wq[i].bz},
          {11'(eq[i].v), 11'(eq[i].v + 512), eq[i].st, eq[i].dn, !eq[i].dn});
      chk({tag, "_lat"}, 64'(wq[i].c), 64'(in_cyc[eq[i].v & 255] + 1));
    end
  endtask

  initial begin
    RST = 1'b0; sync_i = 1'b0; valid_i = 1'b0;
    ar_i = '0; ai_i = '0; fifo_level_i = '0;
    @(negedge CLK);
    chk("reset_outs", {wr_en_o, ar_o, ai_o, sym_start_o, frame_done_o, sym_idx_o, drop_cnt_o, busy_o}, 64'd0);
    RST = 1'b1;
    idle(2);

    // Basic frame: contiguous samples.
    cycle(1'b1, 1'b0, 0, 8'd0);
    for (int v = 0; v < 160; v++) cycle(1'b0, 1'b1, v, 8'd0);
    idle(3);
    add_exp(16, 79, 1'b0);
    add_exp(96, 159, 1'b1);
    check_writes("basic");
    chk("basic_status", {busy_o, sym_idx_o, drop_cnt_o}, {1'b0, 8'd1, 8'd0});

    // Gapped input; FIFO exactly NFFT free at both checks still admits data.
    do_reset();
    cycle(1'b1, 1'b0, 0, 8'd0);
    for (int v = 0; v < 160; v++) begin
      cycle(1'b0, 1'b1, v, (v == 15 || v == 95) ? 8'd64 : 8'd0);
      idle(2);
    end
    idle(2);
    add_exp(16, 79, 1'b0);
    add_exp(96, 159, 1'b1);
    check_writes("gapped");
    chk("gapped_drop", 64'(drop_cnt_o), 64'd0);

    // Backpressure: one word short at the symbol-0 check.
    do_reset();
    cycle(1'b1, 1'b0, 0, 8'd0);
    for (int v = 0; v < 160; v++) begin
      cycle(1'b0, 1'b1, v, (v == 15) ? 8'd65 : 8'd0);
      if (v == 15) chk("bp_drop_entry", 64'(drop_cnt_o), 64'd1);
    end
    idle(3);
    add_exp(96, 159, 1'b1);
    check_writes("bp");
    chk("bp_drop", 64'(drop_cnt_o), 64'd1);

    // Resync in the middle of symbol 1's data.
    do_reset();
    cycle(1'b1, 1'b0, 0, 8'd0);
    for (int v = 0; v < 106; v++) cycle(1'b0, 1'b1, v, 8'd0);
    chk("rs_idx_before", 64'(sym_idx_o), 64'd1);
    cycle(1'b1, 1'b1, 106, 8'd0);
    chk("rs_after", {wr_en_o, sym_idx_o, drop_cnt_o, busy_o}, {1'b0, 8'd0, 8'd1, 1'b1});
    for (int v = 107; v < 186; v++) cycle(1'b0, 1'b1, v, 8'd0);
    idle(3);
    add_exp(16, 79, 1'b0);
    add_exp(96, 105, 1'b0);
    add_exp(122, 185, 1'b0);
    check_writes("resync");

    // Asynchronous reset during DATA.
    do_reset();
    cycle(1'b1, 1'b0, 0, 8'd0);
    for (int v = 0; v < 30; v++) cycle(1'b0, 1'b1, v, 8'd0);
    valid_i = 1'b0;
    chk("rst_pre", {wr_en_o, ar_o, busy_o}, {1'b1, 11'd29, 1'b1});
    #2 RST = 1'b0;
    #1 chk("rst_async", {wr_en_o, ar_o, ai_o, sym_start_o, frame_done_o, sym_idx_o, drop_cnt_o, busy_o}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    wq.delete();
    for (int v = 0; v < 50; v++) cycle(1'b0, 1'b1, v, 8'd0);
    idle(3);
    chk("rst_no_writes", 64'(wq.size()), 64'd0);
    chk("rst_idle", 64'(busy_o), 64'd0);

    // Drop counter saturation with a nearly full FIFO.
    do_reset();
    for (int f = 0; f < 150; f++) begin
      if (f == 127) chk("sat_254", 64'(drop_cnt_o), 64'd254);
      cycle(1'b1, 1'b0, 0, 8'd127);
      for (int v = 0; v < 160; v++) cycle(1'b0, 1'b1, v, 8'd127);
    end
    idle(3);
    chk("sat_255", 64'(drop_cnt_o), 64'd255);
    chk("sat_no_writes", 64'(wq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/comm_sym_ctrl.md
Name: comm_sym_ctrl

Overview:
- Symbol scheduler between rescale and fftfifo in the OFDM receive chain.
- Aligns to a frame-sync pulse, discards the cyclic prefix of each symbol, and forwards exactly NFFT useful samples per symbol into the FFT FIFO.
- Drops whole symbols when the FIFO cannot absorb them, so the FFT never sees a partial 64-point block.
- Reports symbol and frame boundaries and the drop count to the demap/memory side.

Parameters:
- WIDTH, 11, bits per I/Q component.
- NFFT, 64, useful samples per symbol.
- CP_LEN, 16, guard samples per symbol; legal range 1..255.
- SYMS, 8, symbols per frame; legal range 1..256.
- FIFO_DEPTH, 128, fftfifo capacity in words; must be >= NFFT.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- sync_i  in  1  frame-start pulse, one cycle.
- valid_i  in  1  input sample strobe.
- ar_i  in  WIDTH  I sample, signed.
- ai_i  in  WIDTH  Q sample, signed.
- fifo_level_i  in  8  current fftfifo occupancy in words.
- wr_en_o  out  1  FIFO write strobe.
- ar_o  out  WIDTH  I sample to FIFO.
- ai_o  out  WIDTH  Q sample to FIFO.
- sym_start_o  out  1  pulse with the first written sample of a symbol.
- frame_done_o  out  1  pulse at the end of the last symbol of a frame.
- sym_idx_o  out  8  index of the current symbol within the frame.
- drop_cnt_o  out  8  saturating count of dropped symbols.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (RST=0, asynchronous):
  - State forced to IDLE.
  - All outputs 0; all counters 0.
  - Reset taken mid-symbol truncates the symbol silently; no further writes occur.
- States: IDLE, GUARD, DATA, SKIP. Counter samp_cnt (8b) counts valid_i samples within the current phase.
- IDLE:
  - Ignores valid_i.
  - sync_i=1 -> GUARD with samp_cnt=0 and sym_idx=0.
  - If valid_i=1 in the same cycle as sync_i, that sample is CP sample 0, so samp_cnt=1 after the edge.
- GUARD:
  - Each valid_i increments samp_cnt; nothing is written.
  - On the valid sample with samp_cnt==CP_LEN-1, evaluate free = FIFO_DEPTH - fifo_level_i in that cycle.
  - free >= NFFT -> DATA; otherwise -> SKIP. samp_cnt resets to 0.
- DATA:
  - Each valid_i sample is registered to ar_o/ai_o with wr_en_o=1 exactly one cycle later. Latency is 1 cycle.
  - sym_start_o accompanies the write of samp_cnt==0.
  - On the sample with samp_cnt==NFFT-1, go to end-of-symbol.
- SKIP:
  - Same counting as DATA, but wr_en_o stays 0.
  - drop_cnt increments once, on entry to SKIP, saturating at 255.
- End-of-symbol:
  - sym_idx==SYMS-1 -> IDLE; frame_done_o pulses one cycle after the last sample, aligned with the last wr_en_o in DATA. sym_idx_o holds its value until the next sync.
  - Otherwise sym_idx increments -> GUARD.
- valid_i gaps: any number of idle cycles is allowed in any state; counters advance only on valid_i.
- sync_i outside IDLE is a resync:
  - Any partial DATA symbol is abandoned; samples already written stay in the FIFO.
  - drop_cnt increments (saturating) if the state was DATA or SKIP.
  - Go to GUARD with sym_idx=0; the coincident-sample rule from IDLE applies.
- sync_i on the final sample of a frame: resync wins, and frame_done_o is not pulsed.
- Outputs are registered. ar_o/ai_o hold their last value when wr_en_o=0.
- The FIFO space check is made once per symbol. The guarantee holds because the FFT drains the FIFO and the ctrl never writes more than NFFT words after a successful check.

Decomposition:
- Shared package comm_pkg:
  - State encoding localparams (ST_IDLE=2'd0, ST_GUARD=2'd1, ST_DATA=2'd2, ST_SKIP=2'd3).
  - Default NFFT, CP_LEN and WIDTH constants, shared with rescale/fft64 instantiations.
- Single module. The output register stage (sample, wr_en and pulse alignment) is small enough to stay inline; no sub-module.

Test Plan:
- Basic frame: SYMS=2, CP_LEN=16, fifo_level_i=0. sync_i then 160 contiguous valid samples with values 0..159 -> 128 writes carrying values 16..79 and 96..159. sym_start_o accompanies values 16 and 96. frame_done_o is in the same cycle as the write of 159. busy_o then falls.
- Gapped input: same stimulus with valid_i=1 every third cycle -> identical write sequence. Each write occurs exactly 1 cycle after its input sample.
- Backpressure drop: fifo_level_i=65 at the last CP sample of symbol 0, and 0 thereafter -> symbol 0 produces no writes and drop_cnt_o=1. Symbol 1 is written normally.
- Resync mid-DATA: sync_i together with valid_i after 10 data writes -> writes stop, drop_cnt_o increments, and sym_idx_o=0. The next 16 samples are discarded, then 64 are written.
- Reset mid-operation: RST low for 1 cycle during DATA -> all outputs 0 immediately, asynchronously. No writes occur until the next sync_i.
- Saturation: 300 forced drops (fifo_level_i=127) -> drop_cnt_o stops at 255.
